pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 48: payload width in bits (PC 32 + opcode 5 + Rs 3 + Rd 3 + shmnt 5).
REQ-002 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 Parameter NOP_VALUE, default 0 (WIDTH bits): value driven on out_data whenever out_valid=0.
REQ-004 clk  input  1  single clock; all state updates on posedge clk only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage accepts payload this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 flush  input  1  synchronous squash of all held entries (branch/jump redirect).
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream accepts payload this cycle.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 occupancy  output  2  number of held entries (0..2).
REQ-014 stall_cnt  output  16  saturating count of back-pressured cycles.

Function
REQ-015 Input transfer = in_valid && in_ready; output transfer = out_valid && out_ready; both evaluated at the same posedge.
REQ-016 SKID=1 states: EMPTY (occ 0), ONE (occ 1, main reg valid), TWO (occ 2, main + skid valid).
REQ-017 EMPTY: in transfer -> ONE, main <= in_data.
REQ-018 ONE: in only -> TWO, skid <= in_data; out only -> EMPTY; in and out -> ONE, main <= in_data; neither -> ONE.
REQ-019 TWO: out transfer -> ONE, main <= skid; no out -> TWO; no input is accepted in TWO.
REQ-020 SKID=1: in_ready = (state != TWO), driven from a flop, with no combinational path from out_ready.
REQ-021 SKID=0: single main reg; in_ready = !out_valid || out_ready (combinational); occupancy never exceeds 1.
REQ-022 out_valid = (occupancy != 0); out_data = main reg when valid, else NOP_VALUE.
REQ-023 Latency: in_data accepted at edge N appears on out_data after edge N when the stage was empty; payload order is strictly FIFO; no entry is dropped or duplicated.
REQ-024 flush=1: at the next posedge state -> EMPTY, all entries discarded, and any same-cycle input transfer is discarded; flush has priority over every other event.
REQ-025 During a flush cycle in_ready and out_valid keep their pre-edge values; downstream ignores the payload of that cycle by its own flush.
REQ-026 stall_cnt increments at each posedge where out_valid && !out_ready, saturates at 16'hFFFF, is unaffected by flush, and clears only on reset.

Reset
REQ-027 rst_n low asynchronously forces state EMPTY, main and skid regs to NOP_VALUE, stall_cnt to 0, and occupancy to 0.
REQ-028 Outputs during and immediately after reset: out_valid=0, out_data=NOP_VALUE, in_ready=1 (both SKID settings), so the forwarding unit sees defined values from the first instruction.
REQ-029 Reset asserted mid-transfer discards held entries; the first posedge after deassertion behaves as EMPTY.

Structure
REQ-030 State encoding (EMPTY/ONE/TWO) and NOP_VALUE for the ISA NOP live in the shared pipeline package; fetch/decode field widths are also package constants from which WIDTH is derived.
REQ-031 One natural sub-module: pipe_skid_ctrl (state machine plus in_ready/load enables), instantiated only when SKID=1; generate selects the SKID=0 path.
REQ-032 One pipe_stage_reg per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), each with its own WIDTH.

Verification
REQ-033 Reset release, no input -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
REQ-034 Stream 0x01..0x05 with in_valid=1 and out_ready=1 (SKID=1) -> out_data 0x01..0x05 on consecutive cycles, one cycle after each accept; occupancy stays 1.
REQ-035 Load 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0; hold for 3 cycles -> stall_cnt=3; then raise out_ready -> 0xA then 0xB, in_ready=1 after the first drain.
REQ-036 occupancy=2 plus flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0, and 0xC is never output.
REQ-037 Hold out_ready=0 with out_valid=1 for 70000 cycles -> stall_cnt=16'hFFFF and holds; rst_n pulse -> 0.
REQ-038 SKID=0, random in_valid/out_ready over 10k cycles -> scoreboard shows in-order, lossless transfer and in_ready == !out_valid || out_ready every cycle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: payload field widths for each stage boundary,
// the skid-buffer state encoding, the ISA NOP word and a saturating helper.
package pipe_stage_reg_pkg;

    // Fetch/decode instruction fields
    localparam int PC_W    = 32;
    localparam int OPC_W   = 5;
    localparam int RS_W    = 3;
    localparam int RD_W    = 3;
    localparam int SHMNT_W = 5;
    localparam int XLEN    = 32;

    // Payload widths for each pipeline boundary
    localparam int IFID_W  = PC_W + OPC_W + RS_W + RD_W + SHMNT_W;      // 48
    localparam int IDEX_W  = PC_W + OPC_W + RD_W + SHMNT_W + 2 * XLEN;
    localparam int EXMEM_W = OPC_W + RD_W + 2 * XLEN;
    localparam int MEMWB_W = RD_W + XLEN + 1;

    // IF/ID payload layout, most significant field first
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [OPC_W-1:0]   opcode;
        logic [RS_W-1:0]    rs;
        logic [RD_W-1:0]    rd;
        logic [SHMNT_W-1:0] shmnt;
    } ifid_t;

    // Skid-buffer states; the encoding equals the number of held entries
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // ISA NOP: the all-zero instruction word
    localparam logic [IFID_W-1:0] NOP_INSN = '0;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_ctrl.sv
// Control for the two-entry skid buffer: tracks how many entries are held,
// produces a registered in_ready and the load enables for the data regs.
module pipe_skid_ctrl
    import pipe_stage_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occupancy,
    output logic       load_main_in,
    output logic       load_main_skid,
    output logic       load_skid
);

    logic [1:0] state_q, state_d;
    logic       in_ready_q;
    logic       in_xfer, out_xfer;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // Next state and data-register load enables; flush overrides everything
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen
                    if (out_xfer) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is precomputed from the next state so it has
    // no combinational path from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register. SKID=1 gives a two-entry skid
// buffer with registered in_ready; SKID=0 gives a single register whose
// in_ready is combinational. Invalid cycles present NOP_VALUE downstream.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH     = IFID_W,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INSN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_cnt
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [15:0]      stall_q, stall_d;

    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign stall_cnt = stall_q;

    generate
        if (SKID != 0) begin : g_skid
            logic             load_main_in, load_main_skid, load_skid;
            logic [WIDTH-1:0] skid_q, skid_d;

            pipe_skid_ctrl u_ctrl (
                .clk            (clk),
                .rst_n          (rst_n),
                .flush          (flush),
                .in_valid       (in_valid),
                .out_ready      (out_ready),
                .in_ready       (in_ready),
                .out_valid      (out_valid),
                .occupancy      (occupancy),
                .load_main_in   (load_main_in),
                .load_main_skid (load_main_skid),
                .load_skid      (load_skid)
            );

            // Main reg takes new input or the skid entry; skid catches overflow
            always_comb begin
                main_d = main_q;
                if (load_main_in) begin
                    main_d = in_data;
                end else if (load_main_skid) begin
                    main_d = skid_q;
                end
                skid_d = load_skid ? in_data : skid_q;
            end

            // Payload registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q <= NOP_VALUE;
                    skid_q <= NOP_VALUE;
                end else begin
                    main_q <= main_d;
                    skid_q <= skid_d;
                end
            end
        end else begin : g_single
            logic valid_q, valid_d;
            logic in_xfer, out_xfer;

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign occupancy = {1'b0, valid_q};
            assign in_xfer   = in_valid && in_ready;
            assign out_xfer  = valid_q && out_ready;

            // Refill on accept, empty on drain; flush drops everything
            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (in_xfer) begin
                    valid_d = 1'b1;
                    main_d  = in_data;
                end else if (out_xfer) begin
                    valid_d = 1'b0;
                end
            end

            // Single payload register with its valid flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    main_q  <= NOP_VALUE;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end
        end
    endgenerate

    // Back-pressure counter, untouched by flush
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready) begin
            stall_d = sat_inc16(stall_q);
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a table of directed vectors plus hand-written
// sequences on a SKID=1 instance, and a randomized scoreboard run on a
// SKID=0 instance in parallel.
module tb_pipe_stage_reg;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    // SKID=1, default width
    logic        rst_n;
    logic        iv1, ir1, fl1, ov1, or1;
    logic [47:0] id1, od1;
    logic [1:0]  occ1;
    logic [15:0] st1;

    // SKID=0, 8-bit payload
    logic        rst0_n;
    logic        iv0, ir0, ov0, or0;
    logic [7:0]  id0, od0;
    logic [1:0]  occ0;
    logic [15:0] st0;

    pipe_stage_reg #(.WIDTH(48), .SKID(1), .NOP_VALUE(48'h0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1), .stall_cnt(st1)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(0), .NOP_VALUE(8'h0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .flush(1'b0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(occ0), .stall_cnt(st0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic ov, input logic [47:0] od,
                        input logic ir, input logic [1:0] occ, input logic [15:0] st);
        chk({tag, " out_valid"}, ov1, ov);
        chk({tag, " out_data"},  od1, od);
        chk({tag, " in_ready"},  ir1, ir);
        chk({tag, " occupancy"}, occ1, occ);
        chk({tag, " stall_cnt"}, st1, st);
    endtask

    typedef struct {
        logic        iv;
        logic [47:0] id;
        logic        orr;
        logic        fl;
        logic        ov;
        logic [47:0] od;
        logic        ir;
        logic [1:0]  occ;
        logic [15:0] st;
    } vec_t;

    // Directed run on the skid instance
    task automatic run_skid();
        vec_t vecs[21];
        // inputs before the edge | outputs after it
        //          iv    id      or    fl  | ov    od      ir    occ   stall
        vecs[0]  = '{1'b1, 48'h01, 1'b1, 1'b0, 1'b1, 48'h01, 1'b1, 2'd1, 16'd0};
        vecs[1]  = '{1'b1, 48'h02, 1'b1, 1'b0, 1'b1, 48'h02, 1'b1, 2'd1, 16'd0};
        vecs[2]  = '{1'b1, 48'h03, 1'b1, 1'b0, 1'b1, 48'h03, 1'b1, 2'd1, 16'd0};
        vecs[3]  = '{1'b1, 48'h04, 1'b1, 1'b0, 1'b1, 48'h04, 1'b1, 2'd1, 16'd0};
        vecs[4]  = '{1'b1, 48'h05, 1'b1, 1'b0, 1'b1, 48'h05, 1'b1, 2'd1, 16'd0};
        vecs[5]  = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 48'h00, 1'b1, 2'd0, 16'd0};
        vecs[6]  = '{1'b0, 48'h00, 1'b0, 1'b0, 1'b0, 48'h00, 1'b1, 2'd0, 16'd0};
        // fill both entries under back-pressure; the B edge already stalls
        vecs[7]  = '{1'b1, 48'h0A, 1'b0, 1'b0, 1'b1, 48'h0A, 1'b1, 2'd1, 16'd0};
        vecs[8]  = '{1'b1, 48'h0B, 1'b0, 1'b0, 1'b1, 48'h0A, 1'b0, 2'd2, 16'd1};
        vecs[9]  = '{1'b1, 48'hEE, 1'b0, 1'b0, 1'b1, 48'h0A, 1'b0, 2'd2, 16'd2};
        vecs[10] = '{1'b0, 48'h00, 1'b0, 1'b0, 1'b1, 48'h0A, 1'b0, 2'd2, 16'd3};
        // drain; 0x0F is offered while in_ready is still low and must be ignored
        vecs[11] = '{1'b1, 48'h0F, 1'b1, 1'b0, 1'b1, 48'h0B, 1'b1, 2'd1, 16'd3};
        vecs[12] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 48'h00, 1'b1, 2'd0, 16'd3};
        // flush from two entries with a same-cycle input of 0x0C
        vecs[13] = '{1'b1, 48'h10, 1'b0, 1'b0, 1'b1, 48'h10, 1'b1, 2'd1, 16'd3};
        vecs[14] = '{1'b1, 48'h11, 1'b0, 1'b0, 1'b1, 48'h10, 1'b0, 2'd2, 16'd4};
        vecs[15] = '{1'b1, 48'h0C, 1'b0, 1'b1, 1'b0, 48'h00, 1'b1, 2'd0, 16'd5};
        vecs[16] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 48'h00, 1'b1, 2'd0, 16'd5};
        // flush from one entry with simultaneous in and out transfers
        vecs[17] = '{1'b1, 48'h12, 1'b1, 1'b0, 1'b1, 48'h12, 1'b1, 2'd1, 16'd5};
        vecs[18] = '{1'b1, 48'h13, 1'b1, 1'b1, 1'b0, 48'h00, 1'b1, 2'd0, 16'd5};
        vecs[19] = '{1'b1, 48'h14, 1'b1, 1'b0, 1'b1, 48'h14, 1'b1, 2'd1, 16'd5};
        vecs[20] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 48'h00, 1'b1, 2'd0, 16'd5};

        rst_n = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b0; fl1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("in reset", 1'b0, 48'h0, 1'b1, 2'd0, 16'd0);
        rst_n = 1'b1;
        #1;
        chk1("after reset", 1'b0, 48'h0, 1'b1, 2'd0, 16'd0);

        foreach (vecs[i]) begin
            iv1 = vecs[i].iv; id1 = vecs[i].id; or1 = vecs[i].orr; fl1 = vecs[i].fl;
            tick1();
            chk1($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir,
                 vecs[i].occ, vecs[i].st);
        end
        fl1 = 1'b0;

        // Reset while two entries are held, then the first edge acts as EMPTY
        iv1 = 1'b1; id1 = 48'h21; or1 = 1'b0;
        tick1();
        id1 = 48'h22;
        tick1();
        chk("midrst pre occupancy", occ1, 2'd2);
        id1 = 48'h24;
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst asserted", 1'b0, 48'h0, 1'b1, 2'd0, 16'd0);
        #1 rst_n = 1'b1;
        iv1 = 1'b1; id1 = 48'h23; or1 = 1'b1;
        tick1();
        chk1("midrst first", 1'b1, 48'h23, 1'b1, 2'd1, 16'd0);
        iv1 = 1'b0;
        tick1();
        chk1("midrst drained", 1'b0, 48'h0, 1'b1, 2'd0, 16'd0);

        // Stall counter saturation with one entry held under back-pressure
        iv1 = 1'b1; id1 = 48'h30; or1 = 1'b0;
        tick1();
        chk("sat load stall_cnt", st1, 16'd0);
        iv1 = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat one-below", st1, 16'hFFFE);
        tick1();
        chk("sat reached", st1, 16'hFFFF);
        repeat (5) tick1();
        chk1("sat holds", 1'b1, 48'h30, 1'b1, 2'd1, 16'hFFFF);
        fl1 = 1'b1;
        tick1();
        fl1 = 1'b0;
        chk1("flush keeps stall", 1'b0, 48'h0, 1'b1, 2'd0, 16'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("rst clears stall_cnt", st1, 16'd0);
        #1 rst_n = 1'b1;
    endtask

    // Random traffic against the single-register instance with a FIFO scoreboard
    task automatic run_single();
        logic [7:0] q[$];
        logic [7:0] seq;
        logic [7:0] exp_d;
        logic       ix, ox;
        int         bad_before;

        rst0_n = 1'b0; iv0 = 1'b0; id0 = '0; or0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst0_n = 1'b1;
        #1;
        chk("s0 reset in_ready", ir0, 1'b1);
        chk("s0 reset out_valid", ov0, 1'b0);
        chk("s0 reset out_data", od0, 8'h00);
        seq = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            iv0 = 1'($urandom_range(0, 1));
            or0 = 1'($urandom_range(0, 1));
            id0 = seq;
            #1;
            bad_before = errors;
            exp_d = (q.size() != 0) ? q[0] : 8'h00;
            chk("s0 out_valid", ov0, q.size() != 0);
            chk("s0 out_data", od0, exp_d);
            chk("s0 in_ready", ir0, (q.size() == 0) || or0);
            chk("s0 occupancy", occ0, q.size());
            if (errors != bad_before) begin
                $display("  s0 cycle %0d", c);
            end
            ix = iv0 && ((q.size() == 0) || or0);
            ox = (q.size() != 0) && or0;
            if (ox) void'(q.pop_front());
            if (ix) begin
                q.push_back(seq);
                seq = seq + 8'd1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; rst0_n = 1'b0;
        fork
            run_skid();
            run_single();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
